// File: rtl/pipe_result_collector_pkg.sv
// pipe_result_collector_pkg
//   Shared sizing helpers and default parameters for the result collector.
//   cnt_w(depth) : width of a counter that holds 0..depth
//   ptr_w(depth) : width of a FIFO pointer (minimum 1 bit)
//   ptr_t        : pointer type for the default depth
package pipe_result_collector_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned DEF_DEPTH   = 4;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [ptr_w(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/pipe_result_collector_fifo.sv
// pipe_result_collector_fifo
//   Result buffer for the collector. Combinational read of the head entry.
//   No internal overflow/underflow checks: the caller guarantees flow.
// Ports
//   clk      in   clock, all state on posedge
//   rst_n    in   synchronous active-low reset (pointers and count)
//   push_i   in   write wdata_i at the tail
//   pop_i    in   retire the head entry
//   wdata_i  in   write data
//   rdata_o  out  head entry
//   count_o  out  number of stored entries (0..DEPTH)
//   empty_o  out  count_o == 0
module pipe_result_collector_fifo
  import pipe_result_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output logic                    empty_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; writes are held off during reset so the head stays stable.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pipe_result_collector.sv
// pipe_result_collector
//   Consumer-side companion to a fixed-latency, no-backpressure pipeline.
//   A valid-tag shift register follows each issue through the pipeline; when
//   the tag emerges, pipe_out is captured into a result FIFO. Issue is throttled
//   by credits (buffered + in-flight < DEPTH) so the downstream may stall freely.
//   Optional macro PIPE_RESULT_COLLECTOR_BYPASS_EN: when the FIFO is empty an
//   emerging result is presented in the same cycle (and not stored if taken).
// Ports
//   clk        in   clock, all state on posedge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream issues an operation this cycle
//   in_ready   out  credit available (registered state only)
//   pipe_out   in   pipeline output, sampled only when the tag emerges
//   out_valid  out  out_data holds a result
//   out_ready  in   downstream accepts the result
//   out_data   out  oldest result
//   occupancy  out  buffered + in-flight results
module pipe_result_collector
  import pipe_result_collector_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        pipe_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [cnt_w(DEPTH)-1:0] occupancy
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [LATENCY-1:0] tag_q, tag_d;
  logic               accept;
  logic               push;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic [WIDTH-1:0]   fifo_rdata;
  logic               fifo_push;
  logic               fifo_pop;

  assign accept = in_valid && in_ready;
  assign push   = tag_q[LATENCY-1];

  always_comb begin
    tag_d    = '0;
    tag_d[0] = accept;
    for (int unsigned i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  // Credits derive from registered state only; a pop frees its credit next cycle.
  assign inflight  = CW'($countones(tag_q));
  assign in_ready  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
  assign occupancy = fifo_count + inflight;

`ifdef PIPE_RESULT_COLLECTOR_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && push;
  assign out_valid = !fifo_empty || push;
  assign out_data  = bypass ? pipe_out : fifo_rdata;
  // A bypassed result taken in the same cycle never occupies storage.
  assign fifo_push = push && !(bypass && out_ready);
  assign fifo_pop  = !fifo_empty && out_ready;
`else
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata;
  assign fifo_push = push;
  assign fifo_pop  = out_valid && out_ready;
`endif

  pipe_result_collector_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (pipe_out),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule
